pool2d_stream: RTL and testbench

POOL2D_STREAM -- requirements
Module: pool2d_stream

---
 rtl/pool_pkg.sv | 14 +
 rtl/pool_linebuf.sv | 22 ++
 rtl/pool2d_stream.sv | 114 +++++++++++
 tb/tb_pool2d_stream.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/pool_pkg.sv
// Shared definitions for the 2x2 stride-2 streaming pooling block.
package pool_pkg;

  typedef enum logic {
    POOL_MAX = 1'b0,
    POOL_AVG = 1'b1
  } pool_mode_e;

  // Horizontal partial needs one guard bit so the avg-mode pair sum cannot overflow.
  function automatic int unsigned partial_w(input int unsigned data_w);
    return data_w + 1;
  endfunction

endpackage

// File: rtl/pool_linebuf.sv
// Single-clock line buffer: synchronous write, asynchronous read, no reset.
module pool_linebuf #(
  parameter int unsigned WIDTH = 17,
  parameter int unsigned DEPTH = 960,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_addr,
  input  logic [WIDTH-1:0] i_wdata,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_addr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/pool2d_stream.sv
// Streaming 2x2 / stride-2 max or floor-average pooling over raster-order pixels.
module pool2d_stream
  import pool_pkg::*;
#(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned COL_NUM = 1920,
  parameter int unsigned ROW_NUM = 128
) (
  input  logic              clk,
  input  logic              Rst_n,
  input  logic [DATA_W-1:0] din,
  input  logic              valid_in,
  input  logic              frame_start,
  input  logic              mode,
  output logic [DATA_W-1:0] result,
  output logic              valid_out,
  output logic              frame_done
);

  localparam int unsigned CW = $clog2(COL_NUM);
  localparam int unsigned RW = $clog2(ROW_NUM);
  localparam int unsigned AW = CW - 1;
  localparam int unsigned PW = partial_w(DATA_W);

  logic [CW-1:0]     r_c_cnt;
  logic [RW-1:0]     r_r_cnt;
  logic [DATA_W-1:0] r_pair;
  pool_mode_e        r_mode;
  logic [DATA_W-1:0] r_result;
  logic              r_valid;
  logic              r_frame_done;

  logic [CW-1:0]        w_c;
  logic [RW-1:0]        w_r;
  logic                 w_c_last;
  logic                 w_r_last;
  logic                 w_origin;
  logic                 w_emit;
  logic                 w_lb_we;
  logic signed [PW-1:0] w_pair_s;
  logic signed [PW-1:0] w_din_s;
  logic signed [PW-1:0] w_partial;
  logic [PW-1:0]        w_lb_rd;
  logic signed [PW-1:0] w_lb_s;
  logic signed [PW-1:0] w_vmax;
  logic [DATA_W+1:0]    w_sum;
  logic [DATA_W-1:0]    w_out;

  // frame_start overrides the counters so the current pixel is (0,0).
  always_comb begin
    w_c       = (valid_in && frame_start) ? '0 : r_c_cnt;
    w_r       = (valid_in && frame_start) ? '0 : r_r_cnt;
    w_c_last  = (w_c == CW'(COL_NUM - 1));
    w_r_last  = (w_r == RW'(ROW_NUM - 1));
    w_origin  = (w_c == '0) && (w_r == '0);
    w_emit    = valid_in && w_c[0] && w_r[0];
    w_lb_we   = valid_in && w_c[0] && !w_r[0];

    w_pair_s  = {r_pair[DATA_W-1], r_pair};
    w_din_s   = {din[DATA_W-1], din};
    if (r_mode == POOL_MAX) w_partial = (w_pair_s > w_din_s) ? w_pair_s : w_din_s;
    else                    w_partial = w_pair_s + w_din_s;

    w_lb_s    = w_lb_rd;
    w_vmax    = (w_lb_s > w_partial) ? w_lb_s : w_partial;
    // Four-pixel sum; dropping the two LSBs is a floor divide by 4.
    w_sum     = {w_lb_s[PW-1], w_lb_s} + {w_partial[PW-1], w_partial};
    w_out     = (r_mode == POOL_MAX) ? w_vmax[DATA_W-1:0] : w_sum[DATA_W+1:2];
  end

  pool_linebuf #(
    .WIDTH (PW),
    .DEPTH (COL_NUM / 2),
    .AW    (AW)
  ) u_linebuf (
    .clk     (clk),
    .i_we    (w_lb_we),
    .i_addr  (w_c[CW-1:1]),
    .i_wdata (w_partial),
    .o_rdata (w_lb_rd)
  );

  always_ff @(posedge clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_c_cnt      <= '0;
      r_r_cnt      <= '0;
      r_pair       <= '0;
      r_mode       <= POOL_MAX;
      r_result     <= '0;
      r_valid      <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_valid      <= w_emit;
      r_frame_done <= w_emit && w_c_last && w_r_last;
      if (w_emit) r_result <= w_out;
      if (valid_in) begin
        if (w_c_last) begin
          r_c_cnt <= '0;
          r_r_cnt <= w_r_last ? '0 : w_r + RW'(1);
        end else begin
          r_c_cnt <= w_c + CW'(1);
          r_r_cnt <= w_r;
        end
        if (!w_c[0]) r_pair <= din;
        if (w_origin) r_mode <= pool_mode_e'(mode);
      end
    end
  end

  assign result     = r_result;
  assign valid_out  = r_valid;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_pool2d_stream.sv
// Scoreboard bench for pool2d_stream on a 4x2 frame with hand-computed results.
module tb_pool2d_stream;

  localparam int unsigned DW = 16;

  logic          clk = 1'b0;
  logic          Rst_n = 1'b0;
  logic          valid_in = 1'b0;
  logic          frame_start = 1'b0;
  logic          mode = 1'b0;
  logic [DW-1:0] din = '0;
  logic [DW-1:0] result;
  logic          valid_out;
  logic          frame_done;

  int unsigned cyc = 0;
  int unsigned checks = 0;
  int unsigned failures = 0;

  typedef struct packed {
    logic [DW-1:0] res;
    logic          fd;
    logic [31:0]   cyc;
  } exp_t;

  exp_t                 sb[$];
  logic signed [DW-1:0] frm [8];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pool2d_stream #(
    .DATA_W  (DW),
    .COL_NUM (4),
    .ROW_NUM (2)
  ) dut (
    .clk         (clk),
    .Rst_n       (Rst_n),
    .din         (din),
    .valid_in    (valid_in),
    .frame_start (frame_start),
    .mode        (mode),
    .result      (result),
    .valid_out   (valid_out),
    .frame_done  (frame_done)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (Rst_n && valid_out) begin
        if (sb.size() == 0) begin
          chk("spurious_valid_out", 32'(valid_out), 0);
        end else begin
          e = sb.pop_front();
          chk("result", 32'(result), 32'(e.res));
          chk("frame_done", 32'(frame_done), 32'(e.fd));
          chk("latency_cycle", cyc, e.cyc);
        end
      end else if (Rst_n && frame_done) begin
        chk("frame_done_without_valid", 32'(frame_done), 0);
      end
    end
  endtask

  // Sends the first n pixels of frm; outputs are expected after pixels 5 and 7.
  task automatic send_frame(input bit fs, input bit m0, input bit mrest, input bit gaps,
                            input logic [DW-1:0] e0, input logic [DW-1:0] e1,
                            input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      if (gaps) begin
        @(negedge clk);
        valid_in    = 1'b0;
        frame_start = 1'b0;
      end
      @(negedge clk);
      valid_in    = 1'b1;
      din         = frm[i];
      frame_start = fs && (i == 0);
      mode        = (i == 0) ? m0 : mrest;
      if (i == 5) sb.push_back('{e0, 1'b0, cyc + 1});
      if (i == 7) sb.push_back('{e1, 1'b1, cyc + 1});
    end
    @(negedge clk);
    valid_in    = 1'b0;
    frame_start = 1'b0;
  endtask

  initial begin
    fork
      monitor();
      begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
      end
    join_none

    repeat (3) @(negedge clk);
    chk("reset_valid_out", 32'(valid_out), 0);
    chk("reset_result", 32'(result), 0);
    chk("reset_frame_done", 32'(frame_done), 0);
    Rst_n = 1'b1;

    frm = '{16'sd1, 16'sd5, -16'sd3, 16'sd2, 16'sd4, 16'sd0, 16'sd7, -16'sd8};
    send_frame(1, 0, 0, 0, 16'd5, 16'd7, 8);          // max
    send_frame(1, 1, 1, 0, 16'd2, 16'hFFFF, 8);       // avg floor: 10>>2, -2>>2
    send_frame(0, 0, 0, 0, 16'd5, 16'd7, 8);          // wrap, no frame_start
    send_frame(1, 0, 0, 1, 16'd5, 16'd7, 8);          // gaps

    frm = '{default: -16'sd32768};
    send_frame(1, 1, 1, 0, 16'h8000, 16'h8000, 8);
    send_frame(1, 0, 0, 0, 16'h8000, 16'h8000, 8);
    frm = '{default: 16'sd32767};
    send_frame(1, 1, 1, 0, 16'h7FFF, 16'h7FFF, 8);

    // Resync: partial frame ending at row 1 col 0, then a new frame
    frm = '{default: 16'sd100};
    send_frame(1, 1, 1, 0, 16'd0, 16'd0, 5);
    frm = '{16'sd1, 16'sd5, -16'sd3, 16'sd2, 16'sd4, 16'sd0, 16'sd7, -16'sd8};
    send_frame(1, 0, 0, 0, 16'd5, 16'd7, 8);

    // Mode lock
    send_frame(1, 1, 0, 0, 16'd2, 16'hFFFF, 8);
    send_frame(1, 0, 1, 0, 16'd5, 16'd7, 8);

    // Reset mid-frame while valid_out is high
    send_frame(1, 0, 0, 0, 16'd0, 16'd0, 5);
    @(negedge clk);
    valid_in    = 1'b1;
    din         = frm[5];
    frame_start = 1'b0;
    mode        = 1'b0;
    @(posedge clk);
    #1;
    valid_in = 1'b0;
    chk("pre_reset_valid_out", 32'(valid_out), 1);
    chk("pre_reset_result", 32'(result), 5);
    Rst_n = 1'b0;
    #1;
    chk("async_reset_valid_out", 32'(valid_out), 0);
    chk("async_reset_result", 32'(result), 0);
    chk("async_reset_frame_done", 32'(frame_done), 0);
    @(negedge clk);
    Rst_n = 1'b1;
    send_frame(0, 1, 1, 0, 16'd2, 16'hFFFF, 8);

    repeat (4) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
